// File: rtl/rx_frame_buffer.sv
// rx_frame_buffer: store-and-forward AXIS receive buffer that forwards only good, in-size frames
module rx_frame_buffer #(
  parameter int DEPTH = 512,
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] s00_axis_tdata,
  input  logic [3:0]  s00_axis_tkeep,
  input  logic        s00_axis_tvalid,
  input  logic        s00_axis_tlast,
  input  logic        s00_axis_tuser,
  output logic [31:0] m00_axis_tdata,
  output logic [3:0]  m00_axis_tkeep,
  output logic        m00_axis_tvalid,
  output logic        m00_axis_tlast,
  input  logic        m00_axis_tready,
  output logic        o_frame_ok,
  output logic        o_drop_overflow,
  output logic        o_drop_size,
  output logic        o_drop_crc,
  output logic [15:0] o_drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [15:0] MIN_B = 16'(MIN_FRAME_BYTES);
  localparam logic [15:0] MAX_B = 16'(MAX_FRAME_BYTES);

  logic [36:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic          stg_valid, stg_last;
  logic [31:0]   stg_data;
  logic [3:0]    stg_keep;
  logic          bad_ovf, tuser_s;
  logic [15:0]   byte_cnt;
  logic          finish, stg_busy, load, zlast, push_old, set_last, runt;
  logic          full, wr_en, f_ovf, f_size, f_crc, f_ok, drop_old, empty, rd_en;
  logic [2:0]    pc;
  logic [16:0]   cnt_sum, drop_sum;

  // Beat classification, commit decision and read handshake; a staged last word is finished
  // the cycle after it is marked, so a new frame's first beat can load staging at the same time
  always_comb begin
    finish = stg_valid && stg_last;
    stg_busy = stg_valid && !stg_last;
    load = s00_axis_tvalid && (s00_axis_tkeep != 4'd0);
    zlast = s00_axis_tvalid && s00_axis_tlast && (s00_axis_tkeep == 4'd0);
    push_old = load && stg_busy;
    set_last = zlast && stg_busy;
    runt = zlast && !stg_busy;
    full = (wr_ptr - rd_ptr) == DEPTH_P;
    wr_en = (push_old || finish) && !full && !bad_ovf;
    f_ovf = bad_ovf || full;
    f_size = !f_ovf && (byte_cnt < MIN_B || byte_cnt > MAX_B);
    f_crc = !f_ovf && !f_size && !tuser_s;
    f_ok = finish && !f_ovf && !f_size && !f_crc;
    drop_old = finish && !f_ok;
    pc = 3'(s00_axis_tkeep[0]) + 3'(s00_axis_tkeep[1]) + 3'(s00_axis_tkeep[2]) + 3'(s00_axis_tkeep[3]);
    cnt_sum = {1'b0, finish ? 16'd0 : byte_cnt} + 17'(load ? pc : 3'd0);
    drop_sum = {1'b0, o_drop_count} + 17'(drop_old) + 17'(runt);
    empty = rd_ptr == commit_ptr;
    rd_en = (!m00_axis_tvalid || m00_axis_tready) && !empty;
  end

  // Word storage; the last flag is set only for the word written in the finish cycle
  always_ff @(posedge i_clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {stg_data, stg_keep, finish};

  // Staging register, per-frame status and pointers with commit or rollback
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      stg_valid <= 1'b0;
      stg_last <= 1'b0;
      stg_data <= '0;
      stg_keep <= '0;
      bad_ovf <= 1'b0;
      tuser_s <= 1'b0;
      byte_cnt <= '0;
      wr_ptr <= '0;
      commit_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (load) begin
        stg_valid <= 1'b1;
        stg_data <= s00_axis_tdata;
        stg_keep <= s00_axis_tkeep;
        stg_last <= s00_axis_tlast;
      end else if (set_last) stg_last <= 1'b1;
      else if (finish) begin
        stg_valid <= 1'b0;
        stg_last <= 1'b0;
      end
      byte_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      bad_ovf <= !finish && (bad_ovf || (push_old && full));
      if (s00_axis_tvalid && s00_axis_tlast) tuser_s <= s00_axis_tuser;
      else if (finish) tuser_s <= 1'b0;
      if (finish) begin
        wr_ptr <= f_ok ? wr_ptr + 1'b1 : commit_ptr;
        if (f_ok) commit_ptr <= wr_ptr + 1'b1;
      end else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end

  // Registered output stage and status pulses
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      m00_axis_tdata <= '0;
      m00_axis_tkeep <= '0;
      m00_axis_tlast <= 1'b0;
      m00_axis_tvalid <= 1'b0;
      o_frame_ok <= 1'b0;
      o_drop_overflow <= 1'b0;
      o_drop_size <= 1'b0;
      o_drop_crc <= 1'b0;
      o_drop_count <= '0;
    end else begin
      if (rd_en) begin
        {m00_axis_tdata, m00_axis_tkeep, m00_axis_tlast} <= mem[rd_ptr[AW-1:0]];
        m00_axis_tvalid <= 1'b1;
      end else if (m00_axis_tready) m00_axis_tvalid <= 1'b0;
      o_frame_ok <= f_ok;
      o_drop_overflow <= finish && f_ovf;
      o_drop_size <= (finish && f_size) || runt;
      o_drop_crc <= finish && f_crc;
      o_drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
endmodule
